// File: rtl/ec_point_unit.sv
`default_nettype none
// ============================================================================
// ec_point_unit : affine point double / add over GF(p), short Weierstrass form.
//   Optional add mode enabled by defining ECC_POINT_ADD_EN (default: double only).
// Revision: 1.0
// ============================================================================
module ec_point_unit #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0] i_x1,
  input  logic [WIDTH-1:0] i_y1,
  input  logic [WIDTH-1:0] i_x2,
  input  logic [WIDTH-1:0] i_y2,
  output logic             o_busy,
  output logic             o_finished,
  output logic [WIDTH-1:0] o_result_x,
  output logic [WIDTH-1:0] o_result_y,
  output logic             o_inf
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] INF_X = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_NUM, S_DEN, S_DIV, S_SQR, S_X3, S_MULY, S_Y3, S_DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a, p, x1, y1;
  logic [WIDTH-1:0]   num, lam, x3, y3;
  logic [WIDTH-1:0]   mul_a, mul_b, acc;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   du, dv, da, db;
  logic               res_inf;
  logic [WIDTH-1:0]   mul_next, den_next, x3_next, div_res;
`ifdef ECC_POINT_ADD_EN
  logic               add;
  logic [WIDTH-1:0]   x2, y2;
`else
  logic               unused_add_ports;
  assign unused_add_ports = ^{i_op, i_x2, i_y2};
`endif

  // Operands are already reduced, so one conditional subtraction suffices.
  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) return s[WIDTH-1:0] - m;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    if (x >= y) return x - y;
    return x - y + m;
  endfunction

  // x/2 mod m for odd m: (x+m)/2 when x is odd, without a wider adder.
  function automatic logic [WIDTH-1:0] mod_half(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] m);
    if (x[0]) return (x >> 1) + (m >> 1) + WIDTH'(1);
    return x >> 1;
  endfunction

  always_comb begin
    mul_next = mod_add(acc, acc, p);
    if (mul_a[cnt]) mul_next = mod_add(mul_next, mul_b, p);
    div_res = (du == WIDTH'(1)) ? da : db;
`ifdef ECC_POINT_ADD_EN
    den_next = add ? mod_sub(x2, x1, p) : mod_add(y1, y1, p);
    x3_next  = mod_sub(mod_sub(acc, x1, p), add ? x2 : x1, p);
`else
    den_next = mod_add(y1, y1, p);
    x3_next  = mod_sub(mod_sub(acc, x1, p), x1, p);
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= S_IDLE;
      {a, p, x1, y1, num, lam, x3, y3} <= '0;
      {mul_a, mul_b, acc, du, dv, da, db} <= '0;
      cnt        <= '0;
      res_inf    <= 1'b0;
      o_busy     <= 1'b0;
      o_finished <= 1'b0;
      o_result_x <= '0;
      o_result_y <= '0;
      o_inf      <= 1'b0;
`ifdef ECC_POINT_ADD_EN
      add        <= 1'b0;
      x2         <= '0;
      y2         <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          o_finished <= 1'b0;
          if (i_start) begin
            a      <= i_a;
            p      <= i_p;
            x1     <= i_x1;
            y1     <= i_y1;
`ifdef ECC_POINT_ADD_EN
            add    <= i_op;
            x2     <= i_x2;
            y2     <= i_y2;
`endif
            o_busy <= 1'b1;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          state <= S_DONE;
          acc   <= '0;
          cnt   <= CNT_W'(WIDTH - 1);
          mul_a <= x1;
          mul_b <= x1;
          if (x1 == INF_X) begin
`ifdef ECC_POINT_ADD_EN
            if (add) begin
              x3      <= x2;
              y3      <= (x2 == INF_X) ? '0 : y2;
              res_inf <= (x2 == INF_X);
            end else
`endif
            begin
              x3 <= INF_X; y3 <= '0; res_inf <= 1'b1;
            end
          end
`ifdef ECC_POINT_ADD_EN
          else if (add && x2 == INF_X) begin
            x3 <= x1; y3 <= y1; res_inf <= 1'b0;
          end else if (add && x1 == x2 && y1 != y2) begin
            x3 <= INF_X; y3 <= '0; res_inf <= 1'b1;
          end else if (add && x1 != x2) begin
            state <= S_NUM;
          end
`endif
          else if (y1 == '0) begin
            x3 <= INF_X; y3 <= '0; res_inf <= 1'b1;
          end else begin
`ifdef ECC_POINT_ADD_EN
            add <= 1'b0;  // P + P falls through to the doubling path
`endif
            state <= S_NUM;
          end
        end
        S_NUM: begin
`ifdef ECC_POINT_ADD_EN
          if (add) begin
            num   <= mod_sub(y2, y1, p);
            state <= S_DEN;
          end else
`endif
          begin
            acc <= mul_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == '0) begin
              num   <= mod_add(mod_add(mod_add(mul_next, mul_next, p), mul_next, p), a, p);
              state <= S_DEN;
            end
          end
        end
        S_DEN: begin
          du    <= den_next;
          dv    <= p;
          da    <= num;
          db    <= '0;
          state <= S_DIV;
        end
        S_DIV: begin
          // Invariants: da*den == du*num and db*den == dv*num (mod p).
          if (du == WIDTH'(1) || dv == WIDTH'(1)) begin
            lam   <= div_res;
            mul_a <= div_res;
            mul_b <= div_res;
            acc   <= '0;
            cnt   <= CNT_W'(WIDTH - 1);
            state <= S_SQR;
          end else if (!du[0]) begin
            du <= du >> 1;
            da <= mod_half(da, p);
          end else if (!dv[0]) begin
            dv <= dv >> 1;
            db <= mod_half(db, p);
          end else if (du >= dv) begin
            du <= (du - dv) >> 1;
            da <= mod_half(mod_sub(da, db, p), p);
          end else begin
            dv <= (dv - du) >> 1;
            db <= mod_half(mod_sub(db, da, p), p);
          end
        end
        S_SQR: begin
          acc <= mul_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) state <= S_X3;
        end
        S_X3: begin
          x3    <= x3_next;
          mul_a <= lam;
          mul_b <= mod_sub(x1, x3_next, p);
          acc   <= '0;
          cnt   <= CNT_W'(WIDTH - 1);
          state <= S_MULY;
        end
        S_MULY: begin
          acc <= mul_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) state <= S_Y3;
        end
        S_Y3: begin
          y3      <= mod_sub(acc, y1, p);
          res_inf <= 1'b0;
          state   <= S_DONE;
        end
        S_DONE: begin
          o_result_x <= x3;
          o_result_y <= y3;
          o_inf      <= res_inf;
          o_finished <= 1'b1;
          o_busy     <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
